// File: rtl/rails_pkg.sv
// Shared definitions for the rails dispatcher and its order checker.
package rails_pkg;

    // Default station depth and train-number width.
    localparam int unsigned MAX_TRAINS_DEF = 10;
    localparam int unsigned W_DEF          = 4;

    // Operation encoding on the serial op stream.
    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    // State encoding, kept as localparams so the checker can decode it too.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_NUM  = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_FIN  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    typedef enum logic [2:0] {
        StIdle = ST_IDLE,
        StNum  = ST_NUM,
        StRun  = ST_RUN,
        StFin  = ST_FIN,
        StErr  = ST_ERR
    } rails_state_t;

endpackage

// File: rtl/rails_stack.sv
// Station stack: LIFO of train numbers with exposed pointer and top entry.
module rails_stack
    import rails_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_TRAINS_DEF,
    parameter int unsigned W     = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic [W-1:0] sp
);

    localparam logic [W-1:0] DepthW = W'(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_sp;
    logic [W-1:0] w_top_idx;

    // Stack pointer; clear wins so a new run always starts empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp <= '0;
        end else if (clear) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + W'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - W'(1);
        end
    end

    // Storage needs no reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            r_mem[r_sp] <= din;
        end
    end

    // Top-of-stack view and status flags.
    always_comb begin
        w_top_idx = r_sp - W'(1);
        empty     = (r_sp == '0);
        full      = (r_sp == DepthW);
        sp        = r_sp;
        dout      = empty ? '0 : r_mem[w_top_idx];
    end

endmodule

// File: rtl/rails_dispatch.sv
// Replays a push/pop station-operation stream for trains 1..N and emits N
// followed by the resulting departure order; aborts on illegal streams.
module rails_dispatch
    import rails_pkg::*;
#(
    parameter int unsigned MAX_TRAINS = MAX_TRAINS_DEF,
    parameter int unsigned W          = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] n_trains,
    input  logic         op_valid,
    input  logic         op,
    output logic         op_ready,
    output logic         busy,
    output logic         num_valid,
    output logic [W-1:0] number,
    output logic         data_valid,
    output logic [W-1:0] data,
    output logic         done,
    output logic         error
);

    // One extra bit so next_in can reach MAX_TRAINS+1 even when MAX_TRAINS = 2^W-1.
    localparam logic [W:0] MaxN = (W+1)'(MAX_TRAINS);

    rails_state_t r_state, w_state_d;

    logic [W-1:0] r_n;
    logic [W:0]   r_next_in;
    logic [W-1:0] r_out_cnt;
    logic [W-1:0] r_data;
    logic         r_data_valid;

    logic         w_accept;
    logic         w_start_ok;
    logic         w_push;
    logic         w_pop;
    logic         w_n_ok;
    logic [W-1:0] w_dout;
    logic         w_empty;
    logic         w_full;
    logic [W-1:0] w_sp;
    logic [W-1:0] w_cnt_inc;

    rails_stack #(
        .DEPTH (MAX_TRAINS),
        .W     (W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .clear (w_start_ok),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_next_in[W-1:0]),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .sp    (w_sp)
    );

    // Next-state decode; ops are only consumed in RUN.
    always_comb begin
        w_state_d  = r_state;
        w_start_ok = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_accept   = op_valid && (r_state == StRun);
        w_n_ok     = (n_trains != '0) && ({1'b0, n_trains} <= MaxN);
        w_cnt_inc  = r_out_cnt + W'(1);
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    if (w_n_ok) begin
                        w_start_ok = 1'b1;
                        w_state_d  = StNum;
                    end else begin
                        w_state_d  = StErr;
                    end
                end
            end
            StNum: begin
                w_state_d = StRun;
            end
            StRun: begin
                if (w_accept) begin
                    if (op == OP_PUSH) begin
                        if ((r_next_in <= {1'b0, r_n}) && !w_full) begin
                            w_push = 1'b1;
                        end else begin
                            w_state_d = StErr;
                        end
                    end else begin
                        if (!w_empty) begin
                            w_pop = 1'b1;
                            if (w_cnt_inc == r_n) begin
                                w_state_d = StFin;
                            end
                        end else begin
                            w_state_d = StErr;
                        end
                    end
                end
            end
            StFin:   w_state_d = StIdle;
            StErr:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State, counters and the registered departure output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_n          <= '0;
            r_next_in    <= (W+1)'(1);
            r_out_cnt    <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_data_valid <= w_pop;
            if (w_pop) begin
                r_data <= w_dout;
            end
            if (w_start_ok) begin
                r_n       <= n_trains;
                r_next_in <= (W+1)'(1);
                r_out_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_next_in <= r_next_in + (W+1)'(1);
                end
                if (w_pop) begin
                    r_out_cnt <= w_cnt_inc;
                end
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        op_ready   = (r_state == StRun);
        busy       = (r_state != StIdle);
        num_valid  = (r_state == StNum);
        done       = (r_state == StFin) || (r_state == StErr);
        error      = (r_state == StErr);
        number     = r_n;
        data       = r_data;
        data_valid = r_data_valid;
    end

endmodule
